// File: rtl/icg_gate_ctrl.sv
// Upstream controller for an integrated clock-gate stage: gates the clock after an idle period,
// wakes on traffic or force_on, and registers the payload onto the gate stage's d0/d1 inputs.
module icg_gate_ctrl #(
  parameter int DATA_W      = 2,
  parameter int IDLE_CYCLES = 8,
  parameter int WAKE_LAT    = 2,
  parameter int CNT_W       = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_act_valid,
  input  logic [DATA_W-1:0] i_act_data,
  output logic              o_act_ready,
  input  logic              i_force_on,
  output logic              o_icg_in,
  output logic [DATA_W-1:0] o_d_out,
  output logic              o_gated,
  output logic [CNT_W-1:0]  o_gated_cycles
);

  localparam int WAKE_W = (WAKE_LAT > 1) ? $clog2(WAKE_LAT) : 1;

  localparam logic [1:0] S_WAKE   = 2'd0;
  localparam logic [1:0] S_ACTIVE = 2'd1;
  localparam logic [1:0] S_GATED  = 2'd2;

  localparam logic [7:0]        IDLE_LAST = 8'(IDLE_CYCLES - 1);
  localparam logic [WAKE_W-1:0] WAKE_LAST = WAKE_W'(WAKE_LAT - 1);

  logic [1:0]        r_state;
  logic [7:0]        r_idle_cnt;
  logic [WAKE_W-1:0] r_wake_cnt;
  logic              r_act_ready;
  logic              r_icg_in;
  logic              r_gated;
  logic [DATA_W-1:0] r_d_out;
  logic [CNT_W-1:0]  r_gated_cycles;

  logic [1:0]        w_state_nxt;
  logic [7:0]        w_idle_nxt;
  logic [WAKE_W-1:0] w_wake_nxt;
  logic              w_accept;

  assign w_accept = r_act_ready & i_act_valid;

  // An accept on the threshold cycle keeps the block ACTIVE; WAKE always runs to completion.
  always_comb begin
    w_state_nxt = r_state;
    w_idle_nxt  = r_idle_cnt;
    w_wake_nxt  = r_wake_cnt;
    case (r_state)
      S_ACTIVE: begin
        if (w_accept || i_force_on) begin
          w_idle_nxt = '0;
        end else if (r_idle_cnt == IDLE_LAST) begin
          w_state_nxt = S_GATED;
          w_idle_nxt  = '0;
        end else begin
          w_idle_nxt = r_idle_cnt + 8'd1;
        end
      end
      S_GATED: begin
        if (i_act_valid || i_force_on) begin
          w_state_nxt = S_WAKE;
          w_wake_nxt  = '0;
        end
      end
      S_WAKE: begin
        if (r_wake_cnt == WAKE_LAST) begin
          w_state_nxt = S_ACTIVE;
          w_wake_nxt  = '0;
        end else begin
          w_wake_nxt = r_wake_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_WAKE;
        w_idle_nxt  = '0;
        w_wake_nxt  = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they stay registered yet track the state exactly.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state        <= S_WAKE;
      r_idle_cnt     <= '0;
      r_wake_cnt     <= '0;
      r_act_ready    <= 1'b0;
      r_icg_in       <= 1'b0;
      r_gated        <= 1'b0;
      r_d_out        <= '0;
      r_gated_cycles <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_idle_cnt  <= w_idle_nxt;
      r_wake_cnt  <= w_wake_nxt;
      r_act_ready <= (w_state_nxt == S_ACTIVE);
      r_icg_in    <= (w_state_nxt == S_GATED);
      r_gated     <= (w_state_nxt == S_GATED);
      if (w_accept) begin
        r_d_out <= i_act_data;
      end
      if (r_gated && (r_gated_cycles != {CNT_W{1'b1}})) begin
        r_gated_cycles <= r_gated_cycles + 1'b1;
      end
    end
  end

  assign o_act_ready    = r_act_ready;
  assign o_icg_in       = r_icg_in;
  assign o_gated        = r_gated;
  assign o_d_out        = r_d_out;
  assign o_gated_cycles = r_gated_cycles;

endmodule
